// File: rtl/fpu_sp_pkg.sv
// fpu_sp_pkg: opcodes, issue-FSM states and constants shared by the FPU issue front-end
package fpu_sp_pkg;
   localparam logic [3:0] FPU_CMD_ADD = 4'h1;
   localparam logic [3:0] FPU_CMD_SUB = 4'h2;
   localparam logic [3:0] FPU_CMD_MUL = 4'h3;
   localparam logic [3:0] FPU_CMD_DIV = 4'h4;
   localparam logic [3:0] FPU_CMD_CMP = 4'h5;
   localparam logic [31:0] FPU_QNAN = 32'h7FC00000;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} issue_state_t;
   function automatic logic fpu_cmd_legal(input logic [3:0] cmd);
      return cmd == FPU_CMD_ADD || cmd == FPU_CMD_SUB || cmd == FPU_CMD_MUL ||
             cmd == FPU_CMD_DIV || cmd == FPU_CMD_CMP;
   endfunction
endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: synchronous FIFO holding queued FPU operations with full/empty flags
module fpu_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_wdata,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0] r_wptr, r_rptr;
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_empty = r_wptr == r_rptr;
   assign o_full = r_wptr[AW-1:0] == r_rptr[AW-1:0] && r_wptr[AW] != r_rptr[AW];
   // Pointers carry a wrap bit so equal indices can mean either full or empty
   always_ff @(posedge clk)
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push && !o_full) r_wptr <= r_wptr + 1'b1;
         if (i_pop && !o_empty) r_rptr <= r_rptr + 1'b1;
      end
   // Storage needs no reset; only entries between the pointers are ever read
   always_ff @(posedge clk)
      if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/fpu_sp_issue.sv
// fpu_sp_issue: buffers tagged ops and sequences them one at a time onto fpu_sp_top.
// Define FPU_ISSUE_TIMEOUT_EN to abort an op the core leaves unanswered for TIMEOUT cycles.
module fpu_sp_issue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
`ifdef FPU_ISSUE_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_din1,
   input  logic [31:0]      in_din2,
   input  logic [3:0]       in_cmd,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      fpu_din1,
   output logic [31:0]      fpu_din2,
   output logic [3:0]       fpu_cmd,
   output logic             fpu_dval,
   input  logic [31:0]      fpu_result,
   input  logic             fpu_rdy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic             busy
);
   import fpu_sp_pkg::*;
   localparam int W = 68 + TAG_W;
   issue_state_t r_state, w_next;
   logic [W-1:0] w_head;
   logic w_full, w_empty, w_pop, w_legal, w_done, w_timeout;
   logic [31:0] r_din1, r_din2, r_result;
   logic [3:0] r_cmd;
   logic r_dval, r_out_valid, r_err;
   logic [TAG_W-1:0] r_tag, r_out_tag;
   fpu_issue_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .i_push(in_valid),
      .i_pop(w_pop),
      .i_wdata({in_tag, in_cmd, in_din2, in_din1}),
      .o_rdata(w_head),
      .o_full(w_full),
      .o_empty(w_empty)
   );
   assign in_ready = !w_full;
   assign w_legal = fpu_cmd_legal(w_head[67:64]);
   assign w_pop = r_state == ST_IDLE && !w_empty && (!r_out_valid || out_ready);
   assign w_done = r_state == ST_ISSUE && (fpu_rdy || w_timeout);
   assign busy = !w_empty || r_state != ST_IDLE;
`ifdef FPU_ISSUE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   // Cycles spent waiting on the current op; restarts whenever the FSM is outside ISSUE
   always_ff @(posedge clk) r_cnt <= (rst || r_state != ST_ISSUE) ? '0 : r_cnt + 1'b1;
   assign w_timeout = r_state == ST_ISSUE && !fpu_rdy && r_cnt == CW'(TIMEOUT - 1);
`else
   assign w_timeout = 1'b0;
`endif
   // State register
   always_ff @(posedge clk) r_state <= rst ? ST_IDLE : w_next;
   // Next state: illegal ops complete from IDLE, GAP always lasts one cycle so the core re-arms
   always_comb begin
      w_next = r_state;
      if (r_state == ST_IDLE && w_pop && w_legal) w_next = ST_ISSUE;
      if (r_state == ST_ISSUE && w_done) w_next = ST_GAP;
      if (r_state == ST_GAP) w_next = ST_IDLE;
   end
   // Core-side operand registers and the single-entry output slot
   always_ff @(posedge clk)
      if (rst) begin
         r_din1 <= '0;
         r_din2 <= '0;
         r_cmd <= '0;
         r_tag <= '0;
         r_dval <= 1'b0;
         r_out_valid <= 1'b0;
         r_result <= '0;
         r_err <= 1'b0;
         r_out_tag <= '0;
      end else begin
         if (w_pop && w_legal) begin
            r_din1 <= w_head[31:0];
            r_din2 <= w_head[63:32];
            r_cmd <= w_head[67:64];
            r_tag <= w_head[W-1:68];
            r_dval <= 1'b1;
         end else if (w_done) r_dval <= 1'b0;
         if (w_pop && !w_legal) begin
            r_out_valid <= 1'b1;
            r_result <= '0;
            r_err <= 1'b1;
            r_out_tag <= w_head[W-1:68];
         end else if (w_done) begin
            r_out_valid <= 1'b1;
            r_result <= fpu_rdy ? fpu_result : FPU_QNAN;
            r_err <= !fpu_rdy;
            r_out_tag <= r_tag;
         end else if (out_ready) r_out_valid <= 1'b0;
      end
   assign fpu_din1 = r_din1;
   assign fpu_din2 = r_din2;
   assign fpu_cmd = r_cmd;
   assign fpu_dval = r_dval;
   assign out_valid = r_out_valid;
   assign out_result = r_result;
   assign out_tag = r_out_tag;
   assign out_err = r_err;
endmodule

// File: tb/tb_fpu_sp_issue.sv
// tb_fpu_sp_issue: randomized and directed checks of fpu_sp_issue against a queue-based reference
module tb_fpu_sp_issue;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   typedef struct packed {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
      logic             err;
   } res_t;

   logic clk = 0, rst = 1;
   logic in_valid = 0, in_ready;
   logic [31:0] in_din1 = 0, in_din2 = 0;
   logic [3:0] in_cmd = 0;
   logic [TAG_W-1:0] in_tag = 0;
   logic [31:0] fpu_din1, fpu_din2, fpu_result;
   logic [3:0] fpu_cmd;
   logic fpu_dval, fpu_rdy;
   logic out_valid, out_ready = 0, out_err, busy;
   logic [31:0] out_result;
   logic [TAG_W-1:0] out_tag;

   int n_checks = 0, n_fail = 0, cyc = 0;
   res_t exp_q[$], got_q[$];
   int dval_rise_q[$];
   logic prev_dval = 0;
   bit core_en = 0, core_fixed = 0, manual_rdy = 0;
   int core_lat = 3;
   logic [31:0] core_fixed_val = 0;

   always #5 clk = ~clk;

   fpu_sp_issue #(
      .DEPTH(DEPTH),
      .TAG_W(TAG_W)
`ifdef FPU_ISSUE_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_din1(in_din1), .in_din2(in_din2), .in_cmd(in_cmd), .in_tag(in_tag),
      .fpu_din1(fpu_din1), .fpu_din2(fpu_din2), .fpu_cmd(fpu_cmd), .fpu_dval(fpu_dval),
      .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_tag(out_tag), .out_err(out_err), .busy(busy)
   );

   // Stand-in arithmetic for the core: any fixed function of the operands will do
   function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
      return (a ^ {b[15:0], b[31:16]}) + {28'd0, c};
   endfunction

   function automatic res_t exp_of(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                   input logic [TAG_W-1:0] t);
      return (c >= 4'h1 && c <= 4'h5) ? {fmodel(a, b, c), t, 1'b0} : {32'h0, t, 1'b1};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: accepted results and the cycles in which fpu_dval rises
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back({out_result, out_tag, out_err});
      if (fpu_dval && !prev_dval) dval_rise_q.push_back(cyc);
      prev_dval <= fpu_dval;
   end

   // Core model: answers after fpu_dval has been high core_lat cycles
   initial begin
      int dcnt;
      dcnt = 0;
      fpu_rdy = 0;
      fpu_result = 0;
      forever begin
         @(posedge clk);
         #2;
         if (core_en) begin
            fpu_rdy = 0;
            if (fpu_dval) begin
               dcnt++;
               if (dcnt >= core_lat) begin
                  fpu_rdy = 1;
                  fpu_result = core_fixed ? core_fixed_val : fmodel(fpu_din1, fpu_din2, fpu_cmd);
                  dcnt = 0;
               end
            end else dcnt = 0;
         end else begin
            dcnt = 0;
            fpu_rdy = manual_rdy;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic drive_push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                             input logic [TAG_W-1:0] t);
      in_valid = 1;
      in_din1 = a;
      in_din2 = b;
      in_cmd = c;
      in_tag = t;
      @(negedge clk);
      if (in_ready) exp_q.push_back(exp_of(a, b, c, t));
      @(posedge clk);
      #1;
      in_valid = 0;
   endtask

   task automatic wait_results(input int n, input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound && !ok; i++) begin
         ok = got_q.size() >= n;
         if (!ok) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, fpu_dval, out_valid, out_err, busy} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 10000", {in_ready, fpu_dval, out_valid, out_err, busy});
      end
      n_checks++;
      if ({fpu_din1, fpu_din2, fpu_cmd, out_result, out_tag} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {fpu_din1, fpu_din2, fpu_cmd, out_result, out_tag});
      end
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, fpu_dval, out_valid, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL post_reset_idle: got %b expected 1000", {in_ready, fpu_dval, out_valid, busy});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      int c0, r0, hi, rise;
      bit ok;
      exp_q.delete();
      got_q.delete();
      core_en = 1;
      core_lat = 5;
      core_fixed = 1;
      core_fixed_val = 32'h41900000;
      out_ready = 1;
      c0 = cyc;
      r0 = dval_rise_q.size();
      drive_push(32'h41400000, 32'h40C00000, 4'h1, 4'd3);
      @(negedge clk);
      n_checks++;
      if (fpu_dval !== 1'b0) begin
         n_fail++;
         $display("FAIL single_dval_c1: got %b expected 0", fpu_dval);
      end
      @(negedge clk);
      n_checks++;
      if ({fpu_dval, fpu_din1, fpu_din2, fpu_cmd} !== {1'b1, 32'h41400000, 32'h40C00000, 4'h1}) begin
         n_fail++;
         $display("FAIL single_issue_c2: got dval=%b %h %h %h expected 1 41400000 40c00000 1",
                  fpu_dval, fpu_din1, fpu_din2, fpu_cmd);
      end
      hi = 1;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
         if (!ok && fpu_dval) hi++;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_timeout: got no out_valid expected out_valid within 40 cycles");
      end
      n_checks++;
      if ({out_result, out_tag, out_err, fpu_dval} !== {32'h41900000, 4'd3, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL single_result: got %h tag=%0d err=%b dval=%b expected 41900000 tag=3 err=0 dval=0",
                  out_result, out_tag, out_err, fpu_dval);
      end
      n_checks++;
      if (hi !== 5) begin
         n_fail++;
         $display("FAIL single_dval_len: got %0d expected 5", hi);
      end
      rise = dval_rise_q.size() > r0 ? dval_rise_q[r0] : -1;
      n_checks++;
      if (rise !== c0 + 2) begin
         n_fail++;
         $display("FAIL single_latency: got cycle %0d expected %0d", rise, c0 + 2);
      end
      core_fixed = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_illegal();
      int r0;
      bit ok;
      exp_q.delete();
      got_q.delete();
      out_ready = 0;
      r0 = dval_rise_q.size();
      drive_push($urandom, $urandom, 4'h9, 4'd7);
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      n_checks++;
      if (!ok || {out_result, out_tag, out_err} !== {32'h0, 4'd7, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_result: got v=%b %h tag=%0d err=%b expected v=1 0 tag=7 err=1",
                  ok, out_result, out_tag, out_err);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if ({out_valid, out_tag, out_err} !== {1'b1, 4'd7, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_hold: got v=%b tag=%0d err=%b expected v=1 tag=7 err=1", out_valid, out_tag, out_err);
      end
      n_checks++;
      if (dval_rise_q.size() !== r0 || fpu_dval !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_no_dval: got %0d rises expected 0", dval_rise_q.size() - r0);
      end
      @(posedge clk);
      #1;
      out_ready = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if ({out_valid, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL illegal_drain: got v=%b busy=%b expected 0 0", out_valid, busy);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_capacity();
      int acc;
      bit stop, ok;
      logic [31:0] a, b;
      exp_q.delete();
      got_q.delete();
      core_en = 0;
      manual_rdy = 0;
      out_ready = 1;
      acc = 0;
      stop = 0;
      for (int i = 0; i < 20 && !stop; i++) begin
         a = $urandom;
         b = $urandom;
         in_valid = 1;
         in_din1 = a;
         in_din2 = b;
         in_cmd = 4'($urandom_range(1, 5));
         in_tag = acc[TAG_W-1:0];
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(exp_of(a, b, in_cmd, in_tag));
            acc++;
         end else stop = 1;
         @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if (acc !== DEPTH + 1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL capacity: got %0d accepted in_ready=%b expected %0d in_ready=0", acc, in_ready, DEPTH + 1);
      end
      @(posedge clk);
      #1;
      in_valid = 0;
      core_lat = $urandom_range(1, 4);
      core_en = 1;
      wait_results(exp_q.size(), 200, ok);
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (!ok || got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL capacity_count: got %0d results expected %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL capacity_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int r0, d, rise;
      bit ok;
      exp_q.delete();
      got_q.delete();
      core_en = 1;
      core_lat = 3;
      out_ready = 0;
      r0 = dval_rise_q.size();
      drive_push($urandom, $urandom, 4'h3, 4'd10);
      drive_push($urandom, $urandom, 4'h4, 4'd11);
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      repeat (8) @(negedge clk);
      n_checks++;
      if (!ok || dval_rise_q.size() !== r0 + 1 || fpu_dval !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_blocked: got %0d issues dval=%b expected 1 issue dval=0", dval_rise_q.size() - r0, fpu_dval);
      end
      n_checks++;
      if ({out_valid, out_result, out_tag} !== {1'b1, exp_q[0].res, exp_q[0].tag}) begin
         n_fail++;
         $display("FAIL b2b_hold: got v=%b %h tag=%0d expected v=1 %h tag=%0d",
                  out_valid, out_result, out_tag, exp_q[0].res, exp_q[0].tag);
      end
      @(posedge clk);
      #1;
      d = cyc;
      out_ready = 1;
      wait_results(2, 40, ok);
      rise = dval_rise_q.size() > r0 + 1 ? dval_rise_q[r0 + 1] : -1;
      n_checks++;
      if (rise !== d + 1) begin
         n_fail++;
         $display("FAIL b2b_second_issue: got cycle %0d expected %0d", rise, d + 1);
      end
      n_checks++;
      if (!ok || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         n_fail++;
         $display("FAIL b2b_results: got %0d results expected %h %h", got_q.size(), exp_q[0], exp_q[1]);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      int n_push, legal, r0, v;
      bit ok;
      logic [31:0] a, b;
      exp_q.delete();
      got_q.delete();
      core_en = 1;
      n_push = 0;
      legal = 0;
      r0 = dval_rise_q.size();
      for (int i = 0; i < 3000 && n_push < 40; i++) begin
         core_lat = $urandom_range(1, 6);
         out_ready = $urandom_range(0, 3) != 0;
         in_valid = $urandom_range(0, 1) != 0;
         a = $urandom;
         b = $urandom;
         v = $urandom_range(6, 16);
         in_din1 = a;
         in_din2 = b;
         in_cmd = $urandom_range(0, 4) == 0 ? (v == 16 ? 4'h0 : v[3:0]) : 4'($urandom_range(1, 5));
         in_tag = TAG_W'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_of(a, b, in_cmd, in_tag));
            n_push++;
            if (in_cmd >= 4'h1 && in_cmd <= 4'h5) legal++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      out_ready = 1;
      wait_results(exp_q.size(), 600, ok);
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (!ok || got_q.size() !== exp_q.size() || n_push !== 40) begin
         n_fail++;
         $display("FAIL random_count: got %0d results of %0d pushes expected %0d", got_q.size(), n_push, exp_q.size());
      end
      n_checks++;
      if (dval_rise_q.size() - r0 !== legal) begin
         n_fail++;
         $display("FAIL random_issues: got %0d core issues expected %0d", dval_rise_q.size() - r0, legal);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_result[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

`ifdef FPU_ISSUE_TIMEOUT_EN
   task automatic test_timeout();
      int hi;
      bit ok;
      exp_q.delete();
      got_q.delete();
      core_en = 0;
      manual_rdy = 0;
      out_ready = 1;
      drive_push($urandom, $urandom, 4'h2, 4'd5);
      hi = 0;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
         if (!ok && fpu_dval) hi++;
      end
      n_checks++;
      if (!ok || {out_result, out_tag, out_err, fpu_dval} !== {32'h7FC00000, 4'd5, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL timeout_result: got v=%b %h tag=%0d err=%b dval=%b expected v=1 7fc00000 tag=5 err=1 dval=0",
                  ok, out_result, out_tag, out_err, fpu_dval);
      end
      n_checks++;
      if (hi !== 8) begin
         n_fail++;
         $display("FAIL timeout_len: got %0d expected 8", hi);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask
`endif

   task automatic test_reset_mid_issue();
      bit ok, bad;
      exp_q.delete();
      got_q.delete();
      core_en = 0;
      manual_rdy = 0;
      out_ready = 1;
      for (int i = 0; i < 3; i++) drive_push($urandom, $urandom, 4'h1, TAG_W'(i));
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = fpu_dval;
      end
      @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      n_checks++;
      if (!ok || {in_ready, fpu_dval, out_valid, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rst_mid_flush: got issued=%b %b expected issued=1 1000", ok, {in_ready, fpu_dval, out_valid, busy});
      end
      @(posedge clk);
      #1;
      manual_rdy = 1;
      @(posedge clk);
      #1;
      manual_rdy = 0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid || fpu_dval || busy) bad = 1;
      end
      n_checks++;
      if (bad || got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_late_rdy: got activity=%b results=%0d expected 0 0", bad, got_q.size());
      end
      n_checks++;
      if ({fpu_din1, fpu_din2, fpu_cmd, out_result, out_tag, out_err} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_values: got %h expected 0", {fpu_din1, fpu_din2, fpu_cmd, out_result, out_tag, out_err});
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_illegal();
      test_capacity();
      test_back_to_back();
      test_random();
`ifdef FPU_ISSUE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_issue();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
